text_port_arbiter: RTL and testbench

- Shares the single character-layer write port (CX/CY/CHAR) between NREQ independent requesters, e.g. a title writer and a switch-positioned label writer.
- Each requester obtains a locked grant for a whole string, described as a start cell and a length, then streams characters through a valid/ready handshake.
- The arbiter auto-advances the cell address and wraps column→row and row→0.
- It sits between the drawing/control logic and the text VRAM write port.

---
 rtl/text_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_text_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_port_arbiter.sv
// Round-robin arbiter sharing the text VRAM write port between NREQ string writers.
// Each grant is locked for a whole string; the cell address auto-advances with column/row wrap.
module text_port_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 16
) (
    input  logic            CLK,
    input  logic            NRST,
    input  logic [NREQ-1:0] REQ,
    input  logic [5*NREQ-1:0] REQ_CX,
    input  logic [4*NREQ-1:0] REQ_CY,
    input  logic [6*NREQ-1:0] REQ_LEN,
    input  logic [NREQ-1:0] DAT_VALID,
    input  logic [8*NREQ-1:0] DAT_CHAR,
    output logic [NREQ-1:0] DAT_READY,
    output logic [NREQ-1:0] GNT,
    output logic [NREQ-1:0] DONE,
    output logic [4:0]      CX,
    output logic [3:0]      CY,
    output logic [7:0]      CHAR,
    output logic            WE,
    output logic            BUSY
);

    localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [4:0]    XMAX    = 5'(COLS - 1);
    localparam logic [3:0]    YMAX    = 4'(ROWS - 1);
    localparam logic [IW-1:0] LASTIDX = IW'(NREQ - 1);

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] last_q, last_d;
    logic [4:0]    cur_x_q, cur_x_d;
    logic [3:0]    cur_y_q, cur_y_d;
    logic [5:0]    rem_q, rem_d;
    logic [4:0]    cx_q, cx_d;
    logic [3:0]    cy_q, cy_d;
    logic [7:0]    char_q, char_d;
    logic          we_q, we_d;

    logic [NREQ-1:0] gnt_vec;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic            cur_valid;
    logic            cur_req;
    logic [7:0]      cur_char;

    always_comb begin
        gnt_vec = '0;
        gnt_vec[gidx_q] = 1'b1;
    end

    // Search from last_q+1 upward, then wrap around to 0..last_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && REQ[IW'(i)] && (IW'(i) > last_q)) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && REQ[IW'(i)]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end

    assign cur_valid = DAT_VALID[gidx_q];
    assign cur_req   = REQ[gidx_q];
    assign cur_char  = DAT_CHAR[8*gidx_q +: 8];

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        rem_d   = rem_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        char_d  = char_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gidx_d  = win_idx;
                    cur_x_d = REQ_CX[5*win_idx +: 5];
                    cur_y_d = REQ_CY[4*win_idx +: 4];
                    rem_d   = REQ_LEN[6*win_idx +: 6];
                    state_d = (REQ_LEN[6*win_idx +: 6] == 6'd0) ? FINISH : STREAM;
                end
            end
            STREAM: begin
                if (cur_valid) begin
                    we_d   = 1'b1;
                    cx_d   = cur_x_q;
                    cy_d   = cur_y_q;
                    char_d = cur_char;
                    rem_d  = rem_q - 6'd1;
                    if (cur_x_q == XMAX) begin
                        cur_x_d = 5'd0;
                        cur_y_d = (cur_y_q == YMAX) ? 4'd0 : cur_y_q + 4'd1;
                    end else begin
                        cur_x_d = cur_x_q + 5'd1;
                    end
                end
                // A dropped request aborts even if this beat was the last one.
                if (!cur_req) begin
                    state_d = IDLE;
                end else if (cur_valid && (rem_q == 6'd1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                last_d  = gidx_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            last_q  <= LASTIDX;
            cur_x_q <= '0;
            cur_y_q <= '0;
            rem_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            char_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            rem_q   <= rem_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            char_q  <= char_d;
            we_q    <= we_d;
        end
    end

    assign GNT       = (state_q != IDLE)   ? gnt_vec : '0;
    assign DAT_READY = (state_q == STREAM) ? gnt_vec : '0;
    assign DONE      = (state_q == FINISH) ? gnt_vec : '0;
    assign BUSY      = (state_q != IDLE);
    assign CX        = cx_q;
    assign CY        = cy_q;
    assign CHAR      = char_q;
    assign WE        = we_q;

endmodule

// File: tb/tb_text_port_arbiter.sv
// Directed bench for text_port_arbiter: grant latency, address wrap, round-robin,
// backpressure, zero-length, abort and mid-stream reset, all with hand-computed values.
module tb_text_port_arbiter;

    logic        CLK = 1'b0;
    logic        NRST;
    logic [1:0]  REQ;
    logic [9:0]  REQ_CX;
    logic [7:0]  REQ_CY;
    logic [11:0] REQ_LEN;
    logic [1:0]  DAT_VALID;
    logic [15:0] DAT_CHAR;
    logic [1:0]  DAT_READY;
    logic [1:0]  GNT;
    logic [1:0]  DONE;
    logic [4:0]  CX;
    logic [3:0]  CY;
    logic [7:0]  CHAR;
    logic        WE;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    text_port_arbiter #(.NREQ(2), .COLS(32), .ROWS(16)) dut (
        .CLK(CLK), .NRST(NRST), .REQ(REQ), .REQ_CX(REQ_CX), .REQ_CY(REQ_CY),
        .REQ_LEN(REQ_LEN), .DAT_VALID(DAT_VALID), .DAT_CHAR(DAT_CHAR),
        .DAT_READY(DAT_READY), .GNT(GNT), .DONE(DONE), .CX(CX), .CY(CY),
        .CHAR(CHAR), .WE(WE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic set_req(input int i, input logic [4:0] cx, input logic [3:0] cy,
                           input logic [5:0] len);
        REQ_CX[5*i +: 5]  = cx;
        REQ_CY[4*i +: 4]  = cy;
        REQ_LEN[6*i +: 6] = len;
    endtask

    task automatic test_reset();
        NRST = 1'b0; REQ = '0; REQ_CX = '0; REQ_CY = '0; REQ_LEN = '0;
        DAT_VALID = '0; DAT_CHAR = '0;
        repeat (3) @(negedge CLK);
        checks++; if ({GNT, DAT_READY, DONE, WE, BUSY} !== 8'h00) begin errors++;
            $display("FAIL reset_ctrl got=%b exp=00000000", {GNT, DAT_READY, DONE, WE, BUSY}); end
        checks++; if ({CX, CY, CHAR} !== 17'h0) begin errors++;
            $display("FAIL reset_addr got=%h exp=0", {CX, CY, CHAR}); end
        NRST = 1'b1;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL reset_idle_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_single();
        logic [7:0] s [4];
        s = '{8'h54, 8'h6f, 8'h79, 8'h6f};
        set_req(0, 5'd3, 4'd2, 6'd4);
        REQ = 2'b01; DAT_VALID = 2'b01; DAT_CHAR[7:0] = s[0];
        @(negedge CLK);
        checks++; if (GNT !== 2'b01) begin errors++;
            $display("FAIL single_gnt got=%b exp=01", GNT); end
        checks++; if (BUSY !== 1'b1) begin errors++;
            $display("FAIL single_busy got=%b exp=1", BUSY); end
        checks++; if (DAT_READY !== 2'b01) begin errors++;
            $display("FAIL single_ready got=%b exp=01", DAT_READY); end
        checks++; if (WE !== 1'b0) begin errors++;
            $display("FAIL single_we_early got=%b exp=0", WE); end
        for (int b = 0; b < 4; b++) begin
            @(negedge CLK);
            checks++; if ({WE, CX, CY, CHAR} !== {1'b1, 5'(3 + b), 4'd2, s[b]}) begin errors++;
                $display("FAIL single_write%0d got=%b,%0d,%0d,%h exp=1,%0d,2,%h",
                         b, WE, CX, CY, CHAR, 3 + b, s[b]); end
            if (b < 3) DAT_CHAR[7:0] = s[b+1];
        end
        checks++; if ({DONE, GNT, DAT_READY} !== 6'b01_01_00) begin errors++;
            $display("FAIL single_done got=%b exp=010100", {DONE, GNT, DAT_READY}); end
        REQ = '0; DAT_VALID = '0;
        @(negedge CLK);
        checks++; if ({GNT, DONE, BUSY, WE} !== 6'b0) begin errors++;
            $display("FAIL single_after got=%b exp=000000", {GNT, DONE, BUSY, WE}); end
    endtask

    task automatic test_wrap();
        logic [4:0] ex [4];
        logic [3:0] ey [4];
        ex = '{5'd30, 5'd31, 5'd0, 5'd1};
        ey = '{4'd15, 4'd15, 4'd0, 4'd0};
        set_req(1, 5'd30, 4'd15, 6'd4);
        REQ = 2'b10; DAT_VALID = 2'b10; DAT_CHAR[15:8] = 8'h41;
        @(negedge CLK);
        checks++; if (GNT !== 2'b10) begin errors++;
            $display("FAIL wrap_gnt got=%b exp=10", GNT); end
        for (int b = 0; b < 4; b++) begin
            DAT_CHAR[15:8] = 8'(8'h41 + b);
            @(negedge CLK);
            checks++; if ({WE, CX, CY, CHAR} !== {1'b1, ex[b], ey[b], 8'(8'h41 + b)}) begin
                errors++;
                $display("FAIL wrap_write%0d got=%b,%0d,%0d,%h exp=1,%0d,%0d,%h",
                         b, WE, CX, CY, CHAR, ex[b], ey[b], 8'h41 + b); end
        end
        checks++; if (DONE !== 2'b10) begin errors++;
            $display("FAIL wrap_done got=%b exp=10", DONE); end
        REQ = '0; DAT_VALID = '0;
        @(negedge CLK);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        set_req(0, 5'd1, 4'd1, 6'd2);
        set_req(1, 5'd5, 4'd5, 6'd2);
        DAT_CHAR = {8'h42, 8'h41};
        REQ = 2'b11; DAT_VALID = 2'b11;
        for (int g = 0; g < 4; g++) begin
            exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge CLK);
            checks++; if (GNT !== exp_g) begin errors++;
                $display("FAIL rr_gnt%0d got=%b exp=%b", g, GNT, exp_g); end
            @(negedge CLK);
            checks++; if ({WE, CX, CHAR} !== ((g % 2 == 0) ? {1'b1, 5'd1, 8'h41}
                                                          : {1'b1, 5'd5, 8'h42})) begin
                errors++;
                $display("FAIL rr_write%0d got=%b,%0d,%h", g, WE, CX, CHAR); end
            @(negedge CLK);
            checks++; if (DONE !== exp_g) begin errors++;
                $display("FAIL rr_done%0d got=%b exp=%b", g, DONE, exp_g); end
            @(negedge CLK);
            checks++; if ({GNT, BUSY} !== 3'b000) begin errors++;
                $display("FAIL rr_gap%0d got=%b exp=000", g, {GNT, BUSY}); end
        end
        REQ = '0; DAT_VALID = '0;
        @(negedge CLK);
    endtask

    task automatic test_backpressure();
        logic v [5];
        int nb;
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        nb = 0;
        set_req(0, 5'd10, 4'd5, 6'd3);
        REQ = 2'b01; DAT_VALID = 2'b10;
        @(negedge CLK);
        checks++; if ({GNT, DAT_READY} !== 4'b0101) begin errors++;
            $display("FAIL bp_gnt got=%b exp=0101", {GNT, DAT_READY}); end
        for (int k = 0; k < 5; k++) begin
            DAT_VALID[0] = v[k];
            DAT_CHAR[7:0] = 8'(8'h30 + k);
            @(negedge CLK);
            checks++; if (WE !== v[k]) begin errors++;
                $display("FAIL bp_we%0d got=%b exp=%b", k, WE, v[k]); end
            if (v[k]) begin
                checks++; if ({CX, CY, CHAR} !== {5'(10 + nb), 4'd5, 8'(8'h30 + k)}) begin
                    errors++;
                    $display("FAIL bp_write%0d got=%0d,%0d,%h exp=%0d,5,%h",
                             k, CX, CY, CHAR, 10 + nb, 8'h30 + k); end
                nb++;
            end
            checks++; if (DAT_READY !== ((k < 4) ? 2'b01 : 2'b00)) begin errors++;
                $display("FAIL bp_ready%0d got=%b", k, DAT_READY); end
        end
        checks++; if (DONE !== 2'b01) begin errors++;
            $display("FAIL bp_done got=%b exp=01", DONE); end
        REQ = '0; DAT_VALID = '0;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL bp_idle got=%b exp=0", BUSY); end
    endtask

    task automatic test_len0_abort();
        set_req(1, 5'd0, 4'd0, 6'd0);
        REQ = 2'b10;
        @(negedge CLK);
        checks++; if ({GNT, DONE, WE, DAT_READY} !== 7'b10_10_0_00) begin errors++;
            $display("FAIL len0 got=%b exp=1010000", {GNT, DONE, WE, DAT_READY}); end
        REQ = '0;
        @(negedge CLK);
        checks++; if ({GNT, DONE} !== 4'b0) begin errors++;
            $display("FAIL len0_after got=%b exp=0000", {GNT, DONE}); end

        set_req(0, 5'd0, 4'd0, 6'd8);
        set_req(1, 5'd20, 4'd7, 6'd1);
        DAT_CHAR = {8'h5a, 8'h61};
        REQ = 2'b11; DAT_VALID = 2'b11;
        @(negedge CLK);
        checks++; if ({GNT, DAT_READY} !== 4'b0101) begin errors++;
            $display("FAIL abort_gnt got=%b exp=0101", {GNT, DAT_READY}); end
        @(negedge CLK);
        checks++; if ({WE, CX, CHAR} !== {1'b1, 5'd0, 8'h61}) begin errors++;
            $display("FAIL abort_w0 got=%b,%0d,%h exp=1,0,61", WE, CX, CHAR); end
        @(negedge CLK);
        checks++; if ({WE, CX} !== {1'b1, 5'd1}) begin errors++;
            $display("FAIL abort_w1 got=%b,%0d exp=1,1", WE, CX); end
        REQ = 2'b10;
        @(negedge CLK);
        checks++; if ({WE, CX, GNT, DONE, BUSY} !== {1'b1, 5'd2, 2'b00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL abort_drop got=%b,%0d,%b,%b,%b exp=1,2,00,00,0",
                     WE, CX, GNT, DONE, BUSY); end
        @(negedge CLK);
        checks++; if ({GNT, WE} !== 3'b100) begin errors++;
            $display("FAIL abort_other_gnt got=%b exp=100", {GNT, WE}); end
        @(negedge CLK);
        checks++; if ({WE, CX, CY, CHAR, DONE} !== {1'b1, 5'd20, 4'd7, 8'h5a, 2'b10}) begin
            errors++;
            $display("FAIL abort_other_write got=%b,%0d,%0d,%h,%b exp=1,20,7,5a,10",
                     WE, CX, CY, CHAR, DONE); end
        REQ = '0; DAT_VALID = '0;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL abort_idle got=%b exp=0", BUSY); end
    endtask

    task automatic test_reset_midstream();
        set_req(0, 5'd4, 4'd4, 6'd0);
        REQ = 2'b01;
        @(negedge CLK);
        checks++; if (DONE !== 2'b01) begin errors++;
            $display("FAIL rst_pre_done got=%b exp=01", DONE); end
        REQ = '0;
        @(negedge CLK);

        set_req(1, 5'd8, 4'd3, 6'd5);
        REQ = 2'b10; DAT_VALID = 2'b10; DAT_CHAR[15:8] = 8'h77;
        @(negedge CLK);
        checks++; if (GNT !== 2'b10) begin errors++;
            $display("FAIL rst_gnt got=%b exp=10", GNT); end
        @(negedge CLK);
        checks++; if ({WE, CX} !== {1'b1, 5'd8}) begin errors++;
            $display("FAIL rst_beat1 got=%b,%0d exp=1,8", WE, CX); end
        NRST = 1'b0;
        @(negedge CLK);
        checks++; if ({GNT, DAT_READY, DONE, WE, BUSY, CX, CY, CHAR} !== 25'h0) begin errors++;
            $display("FAIL rst_mid got=%h exp=0",
                     {GNT, DAT_READY, DONE, WE, BUSY, CX, CY, CHAR}); end
        NRST = 1'b1;
        set_req(0, 5'd12, 4'd6, 6'd1);
        set_req(1, 5'd13, 4'd6, 6'd1);
        DAT_CHAR = {8'h62, 8'h61};
        REQ = 2'b11; DAT_VALID = 2'b11;
        @(negedge CLK);
        checks++; if ({GNT, WE, DONE} !== 5'b01_0_00) begin errors++;
            $display("FAIL rst_fresh_gnt got=%b exp=01000", {GNT, WE, DONE}); end
        @(negedge CLK);
        checks++; if ({WE, CX, CY, CHAR, DONE} !== {1'b1, 5'd12, 4'd6, 8'h61, 2'b01}) begin
            errors++;
            $display("FAIL rst_fresh_write got=%b,%0d,%0d,%h,%b exp=1,12,6,61,01",
                     WE, CX, CY, CHAR, DONE); end
        REQ = '0; DAT_VALID = '0;
        @(negedge CLK);
        checks++; if ({BUSY, WE} !== 2'b00) begin errors++;
            $display("FAIL rst_fresh_idle got=%b exp=00", {BUSY, WE}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_backpressure();
        test_len0_abort();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
